// File: rtl/mem_port_scheduler_pkg.sv
// Shared constants and helpers for the main-memory port scheduler.
package mem_port_scheduler_pkg;

    // Line and address widths shared with the rest of the memory subsystem.
    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    // Scheduler FSM encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_scheduler_picker.sv
// Combinational grant picker: starved requesters first, then fixed priority
// with index 0 highest inside whichever group is selected.
module prio_starve_picker
    import mem_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] starved_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [NUM_PORTS-1:0] cand;

    // Narrow to starved requesters if any exist, then pick the lowest index.
    always_comb begin
        cand    = (|(req_i & starved_i)) ? (req_i & starved_i) : req_i;
        grant_o = '0;
        idx_o   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Schedules several line-request ports onto the single main-memory port,
// one transaction in flight, with starvation promotion and a reply watchdog.
//
// Handshake: a port raises req (with we/addr/wdata stable) and holds it until
// it sees its ready pulse; ready is a single-cycle completion strobe, err
// accompanies ready when the watchdog aborted the transaction. A req still
// high the cycle after ready is a new request. Towards memory, mem_req is a
// one-cycle launch strobe carrying mem_we/mem_addr/mem_wdata, and mem_ready is
// a one-cycle completion strobe carrying mem_rdata; mem_ready seen while idle
// is a stale reply and is dropped.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*LINE_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ready,
    output logic [NUM_PORTS-1:0]        err,
    output logic [LINE_W-1:0]           rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic [LINE_W-1:0]           mem_rdata,
    input  logic                        mem_ready,
    output logic                        timeout_flag,
    output logic [0:0]                  dbg_state_o
);

    localparam int IDX_W  = cnt_width(NUM_PORTS - 1);
    localparam int WAIT_W = cnt_width(STARVE_LIMIT);
    localparam int TMO_W  = cnt_width((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic              WDOG_EN  = (TIMEOUT_CYCLES > 0);

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [WAIT_W-1:0]    wait_cnt_q [NUM_PORTS];
    logic [WAIT_W-1:0]    wait_cnt_d [NUM_PORTS];
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_PORTS-1:0] starved;
    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 launch, complete, abort;

    // A port is starved once it has lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved[i] = (wait_cnt_q[i] == WAIT_MAX);
        end
    end

    prio_starve_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i     (req),
        .starved_i (starved),
        .grant_o   (grant),
        .idx_o     (win_idx)
    );

    // Per-cycle events; a real reply beats a watchdog expiry in the same cycle.
    always_comb begin
        launch   = (state_q == ST_IDLE) && (|req);
        complete = (state_q == ST_BUSY) && mem_ready;
        abort    = WDOG_EN && (state_q == ST_BUSY) && !mem_ready && (tmo_cnt_q == TMO_LAST);
    end

    // FSM, owner, watchdog counter and sticky timeout flag next-state.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        if (launch) begin
            state_d   = ST_BUSY;
            owner_d   = win_idx;
            tmo_cnt_d = '0;
        end else if (complete) begin
            state_d = ST_IDLE;
        end else if (abort) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
        end else if ((state_q == ST_BUSY) && WDOG_EN) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Wait counters: dropped req clears; on launch the winner clears and
    // every other requester counts up, saturating at the limit.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!req[i]) begin
                wait_cnt_d[i] = '0;
            end else if (launch) begin
                if (grant[i]) begin
                    wait_cnt_d[i] = '0;
                end else if (wait_cnt_q[i] != WAIT_MAX) begin
                    wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
                end
            end
        end
    end

    // Output steering; everything is forced low while reset is asserted.
    always_comb begin
        ready     = '0;
        err       = '0;
        rdata     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (launch) begin
                mem_req   = 1'b1;
                mem_we    = we[win_idx];
                mem_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
                mem_wdata = wdata[int'(win_idx)*LINE_W +: LINE_W];
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((complete || abort) && (owner_q == IDX_W'(i))) begin
                    ready[i] = 1'b1;
                    err[i]   = abort;
                end
            end
            if (complete) begin
                rdata = mem_rdata;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign timeout_flag = timeout_q;
    assign dbg_state_o  = state_q;

endmodule
